// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate L1 data cache with
// 16-byte lines sitting between an RV32 load/store unit and a block memory.
//
// Parameters:
//   LINES          number of lines (power of two, 2..64)
// Ports:
//   CLK, RST       clock; asynchronous active-high reset
//   READ[3:0]      load request: [3] valid, [2:0] funct3 (LB/LH/LW/LBU/LHU)
//   WRITE[2:0]     store request: [2] valid, [1:0] funct3 (SB/SH/SW)
//   ADDRESS        CPU byte address
//   WRITEDATA      store data, right-aligned
//   READDATA       load result, sign/zero-extended (0 when no load hit)
//   BUSYWAIT       CPU stall request
//   MEM_*          block-memory port (28-bit block address, 128-bit lines)
//   HIT_COUNT,
//   MISS_COUNT     statistics counters, only when DCACHE_STATS_EN is defined
//
// Build option: define DCACHE_STATS_EN to add the hit/miss counters.
module data_cache #(
  parameter int unsigned LINES = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [3:0]   READ,
  input  logic [2:0]   WRITE,
  input  logic [31:0]  ADDRESS,
  input  logic [31:0]  WRITEDATA,
  output logic [31:0]  READDATA,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [27:0]  MEM_ADDRESS,
  output logic [127:0] MEM_WRITEDATA,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  HIT_COUNT,
  output logic [31:0]  MISS_COUNT
`endif
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;

  state_t r_state, w_next;

  logic [127:0]     r_data [LINES];
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;

  // Miss context captured on leaving IDLE so the refill ignores CPU input changes
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_req_tag;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_wr_req, w_rd_req, w_req, w_hit, w_wr_hit, w_miss;
  logic [1:0]       w_size;
  logic [3:0]       w_off;
  logic [15:0]      w_be;
  logic [127:0]     w_line, w_line_wr, w_wr_shift;
  logic [31:0]      w_rword, w_load;

  // Request decode; a store wins when both requests are valid
  assign w_idx    = ADDRESS[IDX_W+3:4];
  assign w_tag    = ADDRESS[31:IDX_W+4];
  assign w_wr_req = WRITE[2];
  assign w_rd_req = READ[3] & ~WRITE[2];
  assign w_req    = w_wr_req | w_rd_req;
  assign w_size   = w_wr_req ? WRITE[1:0] : READ[1:0];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_wr_hit = (r_state == IDLE) && w_wr_req && w_hit;
  assign w_line   = r_data[w_idx];

  // Natural alignment of the byte offset plus the matching byte-enable mask
  always_comb begin
    w_off = ADDRESS[3:0];
    w_be  = 16'h000F;
    case (w_size)
      2'b00: begin
        w_off = ADDRESS[3:0];
        w_be  = 16'h0001;
      end
      2'b01: begin
        w_off = {ADDRESS[3:1], 1'b0};
        w_be  = 16'h0003;
      end
      default: begin
        w_off = {ADDRESS[3:2], 2'b00};
        w_be  = 16'h000F;
      end
    endcase
    w_be = w_be << w_off;
  end

  // Store merge: replace only the enabled bytes of the resident line
  assign w_wr_shift = 128'(WRITEDATA) << {w_off, 3'b000};

  always_comb begin
    w_line_wr = w_line;
    for (int i = 0; i < 16; i++) begin
      if (w_be[i]) begin
        w_line_wr[8*i +: 8] = w_wr_shift[8*i +: 8];
      end
    end
  end

  // Load extraction and extension by funct3
  assign w_rword = 32'(w_line >> {w_off, 3'b000});

  always_comb begin
    w_load = w_rword;
    case (READ[2:0])
      3'b000:  w_load = {{24{w_rword[7]}}, w_rword[7:0]};
      3'b001:  w_load = {{16{w_rword[15]}}, w_rword[15:0]};
      3'b100:  w_load = {24'h000000, w_rword[7:0]};
      3'b101:  w_load = {16'h0000, w_rword[15:0]};
      default: w_load = w_rword;
    endcase
  end

  assign READDATA = (!RST && (r_state == IDLE) && w_rd_req && w_hit) ? w_load : 32'h0;

  // The victim line is the only thing memory ever receives
  assign MEM_WRITEDATA = r_data[r_idx];

  // Next-state and memory-port decode
  always_comb begin
    w_next      = r_state;
    BUSYWAIT    = 1'b0;
    MEM_READ    = 1'b0;
    MEM_WRITE   = 1'b0;
    MEM_ADDRESS = 28'h0;
    w_miss      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req && !w_hit) begin
          BUSYWAIT = 1'b1;
          w_miss   = 1'b1;
          w_next   = (r_valid[w_idx] && r_dirty[w_idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        BUSYWAIT    = 1'b1;
        MEM_WRITE   = 1'b1;
        MEM_ADDRESS = {r_tag[r_idx], r_idx};
        if (!MEM_BUSYWAIT) w_next = ALLOCATE;
      end
      ALLOCATE: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {r_req_tag, r_idx};
        if (!MEM_BUSYWAIT) w_next = UPDATE;
      end
      UPDATE: begin
        BUSYWAIT = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Reset is asynchronous; keep the CPU side quiet for its whole duration
    if (RST) begin
      BUSYWAIT = 1'b0;
      w_miss   = 1'b0;
    end
  end

  // State, valid/dirty and miss context
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_valid   <= '0;
      r_dirty   <= '0;
      r_idx     <= '0;
      r_req_tag <= '0;
    end else begin
      r_state <= w_next;
      if (w_miss) begin
        r_idx     <= w_idx;
        r_req_tag <= w_tag;
      end
      if (w_wr_hit) r_dirty[w_idx] <= 1'b1;
      if (r_state == UPDATE) begin
        r_valid[r_idx] <= 1'b1;
        r_dirty[r_idx] <= 1'b0;
      end
    end
  end

  // Data and tag arrays carry no reset; valid bits gate their use
  always_ff @(posedge CLK) begin
    if (w_wr_hit) r_data[w_idx] <= w_line_wr;
    if (r_state == UPDATE) begin
      r_data[r_idx] <= MEM_READDATA;
      r_tag[r_idx]  <= r_req_tag;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        r_after_refill;
  logic [31:0] r_hit_count, r_miss_count;

  // The hit that closes a refill is part of the miss, not a fresh hit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_after_refill <= 1'b0;
      r_hit_count    <= 32'h0;
      r_miss_count   <= 32'h0;
    end else begin
      r_after_refill <= (r_state == UPDATE);
      if ((r_state == IDLE) && w_req && w_hit && !r_after_refill) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign HIT_COUNT  = r_hit_count;
  assign MISS_COUNT = r_miss_count;
`endif

endmodule
